// File: rtl/mem_access_unit.sv
// Memory stage: single-outstanding req/gnt/rvalid data bus, lane steering, load extension, registered writeback.
// Optional MEM_MISALIGN_TRAP_EN adds o_misaligned and completes misaligned accesses without a bus request.
package mem_pkg;
  localparam int XLEN = 32;

  typedef struct packed {
    logic       mem;
    logic       iop;
    logic [2:0] fcs_opcode;
    logic [4:0] rd;
  } control_mem_s;
endpackage

module mem_access_unit
  import mem_pkg::*;
#(
  parameter int BUS_TIMEOUT = 255,
  parameter int TMO_W       = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  input  control_mem_s     i_control_signal,
  input  logic [XLEN-1:0]  i_alu_result,
  input  logic [XLEN-1:0]  i_store_data,
  output logic             o_stall,
  output logic             o_dmem_req,
  output logic             o_dmem_we,
  output logic [XLEN-1:0]  o_dmem_addr,
  output logic [XLEN-1:0]  o_dmem_wdata,
  output logic [3:0]       o_dmem_be,
  input  logic             i_dmem_gnt,
  input  logic             i_dmem_rvalid,
  input  logic [XLEN-1:0]  i_dmem_rdata,
  output logic             o_wb_valid,
  output logic             o_wb_we,
  output logic [4:0]       o_wb_rd,
  output logic [XLEN-1:0]  o_wb_data,
  output logic             o_bus_err
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic             o_misaligned
`endif
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_R, DONE} state_e;

  localparam bit               TMO_EN   = (BUS_TIMEOUT != 0);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(BUS_TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]   sdata_q, sdata_d;
  logic [2:0]        f3_q, f3_d;
  logic [4:0]        rd_q, rd_d;
  logic              store_q, store_d;
  logic [TMO_W-1:0]  cnt_q, cnt_d;
  logic              wb_we_q, wb_we_d;
  logic [XLEN-1:0]   wb_data_q, wb_data_d;
  logic              bus_err_q, bus_err_d;
`ifdef MEM_MISALIGN_TRAP_EN
  logic              mis_q, mis_d;
`endif

  logic              accept;
  logic              mis_w;
  logic              tmo_hit;
  logic [3:0]        be_w;
  logic [XLEN-1:0]   wdata_w;
  logic [XLEN-1:0]   load_w;
  logic [4:0]        byte_sh;
  logic [4:0]        half_sh;
  logic [7:0]        byte_w;
  logic [15:0]       half_w;

  assign accept  = i_valid && (state_q == IDLE || state_q == DONE);
  assign tmo_hit = TMO_EN && (cnt_q == TMO_LAST);

`ifdef MEM_MISALIGN_TRAP_EN
  assign mis_w = i_control_signal.mem &&
                 (((i_control_signal.fcs_opcode[1:0] == 2'b01) && i_alu_result[0]) ||
                  ((i_control_signal.fcs_opcode == 3'b010) && (i_alu_result[1:0] != 2'b00)));
`else
  assign mis_w = 1'b0;
`endif

  // Loads always read the full word; only stores narrow the byte enables.
  always_comb begin
    be_w    = 4'b1111;
    wdata_w = sdata_q;
    if (store_q) begin
      case (f3_q)
        3'b000: begin
          be_w    = 4'b0001 << addr_q[1:0];
          wdata_w = {4{sdata_q[7:0]}};
        end
        3'b001: begin
          be_w    = addr_q[1] ? 4'b1100 : 4'b0011;
          wdata_w = {2{sdata_q[15:0]}};
        end
        default: ;
      endcase
    end
  end

  assign byte_sh = {addr_q[1:0], 3'b000};
  assign half_sh = {addr_q[1], 4'b0000};
  assign byte_w  = i_dmem_rdata[byte_sh +: 8];
  assign half_w  = i_dmem_rdata[half_sh +: 16];

  always_comb begin
    case (f3_q)
      3'b000:  load_w = {{24{byte_w[7]}}, byte_w};
      3'b100:  load_w = {24'd0, byte_w};
      3'b001:  load_w = {{16{half_w[15]}}, half_w};
      3'b101:  load_w = {16'd0, half_w};
      default: load_w = i_dmem_rdata;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    sdata_d   = sdata_q;
    f3_d      = f3_q;
    rd_d      = rd_q;
    store_d   = store_q;
    cnt_d     = cnt_q;
    wb_we_d   = wb_we_q;
    wb_data_d = wb_data_q;
    bus_err_d = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
    mis_d     = 1'b0;
`endif
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (accept) begin
          addr_d  = i_alu_result;
          sdata_d = i_store_data;
          f3_d    = i_control_signal.fcs_opcode;
          rd_d    = i_control_signal.rd;
          store_d = i_control_signal.iop;
          cnt_d   = '0;
          if (!i_control_signal.mem) begin
            state_d   = DONE;
            wb_data_d = i_alu_result;
            wb_we_d   = (i_control_signal.rd != 5'd0);
          end else if (mis_w) begin
            state_d = DONE;
            wb_we_d = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
            mis_d   = 1'b1;
`endif
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        cnt_d = cnt_q + TMO_W'(1);
        if (i_dmem_gnt) begin
          if (store_q) begin
            state_d = DONE;
            wb_we_d = 1'b0;
          end else if (i_dmem_rvalid) begin
            state_d   = DONE;
            wb_data_d = load_w;
            wb_we_d   = (rd_q != 5'd0);
          end else begin
            state_d = WAIT_R;
          end
        end else if (tmo_hit) begin
          state_d   = DONE;
          wb_we_d   = 1'b0;
          bus_err_d = 1'b1;
        end
      end
      WAIT_R: begin
        cnt_d = cnt_q + TMO_W'(1);
        if (i_dmem_rvalid) begin
          state_d   = DONE;
          wb_data_d = load_w;
          wb_we_d   = (rd_q != 5'd0);
        end else if (tmo_hit) begin
          state_d   = DONE;
          wb_we_d   = 1'b0;
          bus_err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      sdata_q   <= '0;
      f3_q      <= '0;
      rd_q      <= '0;
      store_q   <= 1'b0;
      cnt_q     <= '0;
      wb_we_q   <= 1'b0;
      wb_data_q <= '0;
      bus_err_q <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      mis_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      sdata_q   <= sdata_d;
      f3_q      <= f3_d;
      rd_q      <= rd_d;
      store_q   <= store_d;
      cnt_q     <= cnt_d;
      wb_we_q   <= wb_we_d;
      wb_data_q <= wb_data_d;
      bus_err_q <= bus_err_d;
`ifdef MEM_MISALIGN_TRAP_EN
      mis_q     <= mis_d;
`endif
    end
  end

  // Bus outputs are gated by REQ so a reset or abort drops them in the same cycle.
  assign o_dmem_req   = (state_q == REQ);
  assign o_dmem_we    = o_dmem_req && store_q;
  assign o_dmem_addr  = o_dmem_req ? {addr_q[XLEN-1:2], 2'b00} : '0;
  assign o_dmem_be    = o_dmem_req ? be_w : 4'b0000;
  assign o_dmem_wdata = o_dmem_req ? wdata_w : '0;

  assign o_stall    = (state_q == REQ) || (state_q == WAIT_R) ||
                      (accept && i_control_signal.mem && !mis_w);
  assign o_wb_valid = (state_q == DONE);
  assign o_wb_we    = o_wb_valid && wb_we_q;
  assign o_wb_rd    = rd_q;
  assign o_wb_data  = wb_data_q;
  assign o_bus_err  = bus_err_q;
`ifdef MEM_MISALIGN_TRAP_EN
  assign o_misaligned = mis_q;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: bus responder with programmable gnt/rvalid delays,
// expected writebacks queued at issue and compared (value and cycle) when o_wb_valid pulses.
module tb_mem_access_unit;
  import mem_pkg::*;

  localparam int TMO = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             i_valid;
  control_mem_s     ctrl;
  logic [31:0]      alu, sdata;
  logic             o_stall, o_dmem_req, o_dmem_we;
  logic [31:0]      o_dmem_addr, o_dmem_wdata;
  logic [3:0]       o_dmem_be;
  logic             i_dmem_gnt, i_dmem_rvalid;
  logic [31:0]      i_dmem_rdata;
  logic             o_wb_valid, o_wb_we;
  logic [4:0]       o_wb_rd;
  logic [31:0]      o_wb_data;
  logic             o_bus_err;
`ifdef MEM_MISALIGN_TRAP_EN
  logic             o_misaligned;
`endif

  mem_access_unit #(.BUS_TIMEOUT(TMO), .TMO_W(8)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .i_control_signal(ctrl),
    .i_alu_result(alu), .i_store_data(sdata), .o_stall(o_stall),
    .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we), .o_dmem_addr(o_dmem_addr),
    .o_dmem_wdata(o_dmem_wdata), .o_dmem_be(o_dmem_be), .i_dmem_gnt(i_dmem_gnt),
    .i_dmem_rvalid(i_dmem_rvalid), .i_dmem_rdata(i_dmem_rdata),
    .o_wb_valid(o_wb_valid), .o_wb_we(o_wb_we), .o_wb_rd(o_wb_rd),
    .o_wb_data(o_wb_data), .o_bus_err(o_bus_err)
`ifdef MEM_MISALIGN_TRAP_EN
    , .o_misaligned(o_misaligned)
`endif
  );

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        err;
    logic        mis;
    int          cyc;
  } wb_exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } bus_exp_t;

  wb_exp_t  wb_q[$];
  bus_exp_t bus_q[$];

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          gnt_delay = 0;
  int          rv_delay = 0;
  bit          gnt_en = 1'b1;
  logic [31:0] mem_rdata = 32'h1234_80FF;
  int          last_req_cycles = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Bus slave: gnt after gnt_delay request cycles, rvalid rv_delay cycles after gnt.
  initial begin
    int  req_wait = 0;
    int  req_cycles = 0;
    int  rv_cnt = 0;
    bit  pend_rv = 1'b0;
    bus_exp_t b;
    i_dmem_gnt = 1'b0;
    i_dmem_rvalid = 1'b0;
    i_dmem_rdata = '0;
    forever begin
      @(negedge clk);
      i_dmem_gnt = 1'b0;
      i_dmem_rvalid = 1'b0;
      i_dmem_rdata = '0;
      if (pend_rv) begin
        if (rv_cnt == 0) begin
          i_dmem_rvalid = 1'b1;
          i_dmem_rdata = mem_rdata;
          pend_rv = 1'b0;
        end else rv_cnt--;
      end
      if (o_dmem_req) begin
        req_cycles++;
        if (gnt_en && req_wait == gnt_delay) begin
          i_dmem_gnt = 1'b1;
          req_wait = 0;
          last_req_cycles = req_cycles;
          req_cycles = 0;
          if (bus_q.size() == 0) check_eq("bus_unexpected", 32'(o_dmem_req), 32'd0);
          else begin
            b = bus_q.pop_front();
            check_eq("bus_addr", o_dmem_addr, b.addr);
            check_eq("bus_we", 32'(o_dmem_we), 32'(b.we));
            if (b.we) begin
              check_eq("bus_be", 32'(o_dmem_be), 32'(b.be));
              check_eq("bus_wdata", o_dmem_wdata, b.wdata);
            end
          end
          if (!o_dmem_we) begin
            if (rv_delay == 0) begin
              i_dmem_rvalid = 1'b1;
              i_dmem_rdata = mem_rdata;
            end else begin
              pend_rv = 1'b1;
              rv_cnt = rv_delay - 1;
            end
          end
        end else req_wait++;
      end else begin
        req_wait = 0;
        req_cycles = 0;
      end
    end
  end

  // Writeback monitor.
  initial begin
    wb_exp_t e;
    forever begin
      @(negedge clk);
      if (o_bus_err) check_eq("bus_err_stray", 32'(o_wb_valid), 32'd1);
      if (o_wb_valid) begin
        if (wb_q.size() == 0) check_eq("wb_unexpected", 32'(o_wb_valid), 32'd0);
        else begin
          e = wb_q.pop_front();
          check_eq("wb_cycle", cyc, e.cyc);
          check_eq("wb_we", 32'(o_wb_we), 32'(e.we));
          check_eq("wb_rd", 32'(o_wb_rd), 32'(e.rd));
          check_eq("wb_bus_err", 32'(o_bus_err), 32'(e.err));
          if (e.we) check_eq("wb_data", o_wb_data, e.data);
`ifdef MEM_MISALIGN_TRAP_EN
          check_eq("wb_misaligned", 32'(o_misaligned), 32'(e.mis));
`endif
        end
      end
    end
  end

  task automatic wait_unstalled();
    for (int n = 0; n < 50 && o_stall; n++) begin
      @(posedge clk);
      #1;
    end
    if (o_stall) check_eq("stall_timeout", 32'(o_stall), 32'd0);
  endtask

  // Called at posedge+1; returns at posedge+1 of the first cycle with stall low.
  task automatic send(input logic mem, input logic iop, input logic [2:0] f3,
                      input logic [4:0] rd, input logic [31:0] addr, input logic [31:0] sd,
                      input logic [3:0] be, input logic [31:0] wdata, input logic [31:0] wbdata,
                      input logic tmo, input logic mis);
    wb_exp_t  e;
    bus_exp_t b;
    int       lat;
    if (!mem || mis) lat = 1;
    else if (tmo) lat = 1 + TMO;
    else lat = gnt_delay + 2 + (iop ? 0 : rv_delay);
    e.we   = (rd != 5'd0) && (!mem || (!iop && !tmo && !mis));
    e.rd   = rd;
    e.data = wbdata;
    e.err  = tmo;
    e.mis  = mis;
    e.cyc  = cyc + lat;
    wb_q.push_back(e);
    if (mem && !mis && !tmo) begin
      b.we = iop;
      b.addr = {addr[31:2], 2'b00};
      b.be = be;
      b.wdata = wdata;
      bus_q.push_back(b);
    end
    ctrl.mem = mem;
    ctrl.iop = iop;
    ctrl.fcs_opcode = f3;
    ctrl.rd = rd;
    alu = addr;
    sdata = sd;
    i_valid = 1'b1;
    #3;
    check_eq("stall_accept", 32'(o_stall), 32'(mem && !mis));
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    wait_unstalled();
  endtask

  initial begin
    bus_exp_t b;
    logic     mis_lw;
    i_valid = 1'b0;
    ctrl = '0;
    alu = '0;
    sdata = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #2;
    check_eq("rst_stall", 32'(o_stall), 32'd0);
    check_eq("rst_req", 32'(o_dmem_req), 32'd0);
    check_eq("rst_we", 32'(o_dmem_we), 32'd0);
    check_eq("rst_addr", o_dmem_addr, 32'd0);
    check_eq("rst_be", 32'(o_dmem_be), 32'd0);
    check_eq("rst_wdata", o_dmem_wdata, 32'd0);
    check_eq("rst_wb_valid", 32'(o_wb_valid), 32'd0);
    check_eq("rst_wb_we", 32'(o_wb_we), 32'd0);
    check_eq("rst_wb_rd", 32'(o_wb_rd), 32'd0);
    check_eq("rst_wb_data", o_wb_data, 32'd0);
    check_eq("rst_bus_err", 32'(o_bus_err), 32'd0);
    @(posedge clk);
    #1;

    // Pass-through ADDI.
    send(0, 0, 3'b000, 5'd3, 32'h5, 0, 0, 0, 32'h5, 0, 0);

    // Stores with slow grant.
    gnt_delay = 2;
    send(1, 1, 3'b000, 5'd0, 32'h1003, 32'h0000_00AB, 4'b1000, 32'hABAB_ABAB, 0, 0, 0);
    check_eq("sb_req_cycles", last_req_cycles, 32'd3);
    gnt_delay = 1;
    send(1, 1, 3'b000, 5'd0, 32'h1000, 32'h0000_00CD, 4'b0001, 32'hCDCD_CDCD, 0, 0, 0);
    send(1, 1, 3'b001, 5'd0, 32'h1002, 32'h0000_BEEF, 4'b1100, 32'hBEEF_BEEF, 0, 0, 0);
    send(1, 1, 3'b001, 5'd0, 32'h1000, 32'h1111_2222, 4'b0011, 32'h2222_2222, 0, 0, 0);
    send(1, 1, 3'b010, 5'd0, 32'h1004, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF, 0, 0, 0);

    // Loads with gnt and rvalid in the same cycle.
    gnt_delay = 0;
    rv_delay = 0;
    send(1, 0, 3'b000, 5'd5, 32'h2001, 0, 4'b1111, 0, 32'hFFFF_FF80, 0, 0);
    send(1, 0, 3'b100, 5'd5, 32'h2001, 0, 4'b1111, 0, 32'h0000_0080, 0, 0);
    send(1, 0, 3'b000, 5'd6, 32'h2003, 0, 4'b1111, 0, 32'h0000_0012, 0, 0);
    send(1, 0, 3'b001, 5'd6, 32'h2002, 0, 4'b1111, 0, 32'h0000_1234, 0, 0);
    send(1, 0, 3'b001, 5'd6, 32'h2000, 0, 4'b1111, 0, 32'hFFFF_80FF, 0, 0);
    send(1, 0, 3'b101, 5'd6, 32'h2000, 0, 4'b1111, 0, 32'h0000_80FF, 0, 0);

    // Delayed rvalid, rd=0, then back-to-back LW/ADD.
    rv_delay = 2;
    send(1, 0, 3'b010, 5'd7, 32'h2000, 0, 4'b1111, 0, 32'h1234_80FF, 0, 0);
    send(1, 0, 3'b010, 5'd0, 32'h2000, 0, 4'b1111, 0, 32'h1234_80FF, 0, 0);
    send(1, 0, 3'b010, 5'd8, 32'h2004, 0, 4'b1111, 0, 32'h1234_80FF, 0, 0);
    send(0, 0, 3'b000, 5'd9, 32'h77, 0, 0, 0, 32'h77, 0, 0);
    rv_delay = 0;

    // Misaligned word accesses.
`ifdef MEM_MISALIGN_TRAP_EN
    mis_lw = 1'b1;
`else
    mis_lw = 1'b0;
`endif
    send(1, 0, 3'b010, 5'd10, 32'h2002, 0, 4'b1111, 0, 32'h1234_80FF, 0, mis_lw);
    send(1, 1, 3'b010, 5'd0, 32'h1006, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D, 0, 0, mis_lw);

    // Grant never arrives: timeout abort.
    gnt_en = 1'b0;
    send(1, 0, 3'b010, 5'd11, 32'h3000, 0, 4'b1111, 0, 0, 1, 0);
    check_eq("tmo_req_drop", 32'(o_dmem_req), 32'd0);
    check_eq("tmo_stall_drop", 32'(o_stall), 32'd0);
    gnt_en = 1'b1;

    // Reset while waiting for read data; the late rvalid must be ignored.
    rv_delay = 5;
    b.we = 1'b0;
    b.addr = 32'h2000;
    b.be = 4'b1111;
    b.wdata = '0;
    bus_q.push_back(b);
    ctrl.mem = 1'b1;
    ctrl.iop = 1'b0;
    ctrl.fcs_opcode = 3'b010;
    ctrl.rd = 5'd12;
    alu = 32'h2000;
    i_valid = 1'b1;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    @(posedge clk);
    #1;
    check_eq("wr_stall", 32'(o_stall), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_eq("mid_rst_req", 32'(o_dmem_req), 32'd0);
    check_eq("mid_rst_stall", 32'(o_stall), 32'd0);
    check_eq("mid_rst_wb_valid", 32'(o_wb_valid), 32'd0);
    check_eq("mid_rst_wb_data", o_wb_data, 32'd0);
    #2;
    rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check_eq("post_rst_stall", 32'(o_stall), 32'd0);
    rv_delay = 0;
    send(1, 0, 3'b010, 5'd12, 32'h2000, 0, 4'b1111, 0, 32'h1234_80FF, 0, 0);

    repeat (5) @(posedge clk);
    #1;
    check_eq("wb_drain", wb_q.size(), 32'd0);
    check_eq("bus_drain", bus_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
